core_feed_sequencer: RTL and testbench

//  Autonomous read sequencer that streams a burst of vectors from the activation and weight SRAMs

---
 rtl/core_feed_sequencer_pkg.sv | 21 ++
 rtl/feed_skid_fifo.sv | 56 +++++
 rtl/core_feed_sequencer.sv | 167 ++++++++++++++++
 tb/tb_core_feed_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_feed_sequencer_pkg.sv
// rtl/core_feed_sequencer_pkg.sv - shared types and constants for the core feed sequencer
package core_feed_sequencer_pkg;

    localparam int CFS_BW     = 4;
    localparam int CFS_ROW    = 8;
    localparam int CFS_ADDR_W = 11;
    localparam int CFS_SKID   = 3;

    localparam logic MODE_WS = 1'b1;
    localparam logic MODE_OS = 1'b0;
    localparam logic DM_WT   = 1'b1;
    localparam logic DM_ACT  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/feed_skid_fifo.sv
// rtl/feed_skid_fifo.sv - small synchronous skid FIFO absorbing SRAM read latency
module feed_skid_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != CW'(DEPTH)) || do_pop);
    end

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/core_feed_sequencer.sv
// rtl/core_feed_sequencer.sv - autonomous SRAM-to-L0/IFIFO burst read sequencer
module core_feed_sequencer
    import core_feed_sequencer_pkg::*;
#(
    parameter int bw     = CFS_BW,
    parameter int row    = CFS_ROW,
    parameter int addr_w = CFS_ADDR_W,
    parameter int SKID   = CFS_SKID
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic                data_mode,
    input  logic [addr_w-1:0]   base_x,
    input  logic [addr_w-1:0]   base_p,
    input  logic [addr_w-1:0]   len,
    output logic                busy,
    output logic                done,
    output logic                CEN_xmem,
    output logic [addr_w-1:0]   A_xmem,
    output logic                CEN_pmem,
    output logic [addr_w-1:0]   A_pmem,
    input  logic [bw*row-1:0]   Q_act,
    input  logic [bw*row-1:0]   Q_wt,
    output logic [bw*row-1:0]   l0_in,
    output logic                l0_wr,
    input  logic                l0_full,
    output logic [bw*row-1:0]   ififo_in,
    output logic                ififo_wr,
    input  logic                ififo_full
);

    localparam int DW = bw * row;
    localparam int CW = $clog2(SKID + 1);

    state_t              state;
    logic                mode_q;
    logic                dm_q;
    logic [addr_w-1:0]   len_q;
    logic [addr_w-1:0]   issued;
    logic [addr_w-1:0]   written;
    logic [addr_w-1:0]   addr_x;
    logic [addr_w-1:0]   addr_p;
    logic                inflight;

    logic [CW-1:0]       act_count;
    logic [CW-1:0]       wt_count;
    logic [DW-1:0]       act_head;
    logic [DW-1:0]       wt_head;
    logic [DW-1:0]       act_push_data;
    logic                is_os;
    logic                issue;
    logic                wr_fire;

    assign is_os = (mode_q == MODE_OS);

    // Credit counts data already held plus the read still in the SRAM pipe;
    // a pop in this cycle is deliberately not credited.
    always_comb begin
        issue = (state == ST_RUN) && (issued != len_q)
                && ((32'(act_count) + 32'(inflight)) < SKID);
    end

    always_comb begin
        if (is_os) begin
            wr_fire = (act_count != '0) && (wt_count != '0) && !l0_full && !ififo_full;
        end else begin
            wr_fire = (act_count != '0) && !l0_full;
        end
    end

    // In WS mode the act-path skid carries whichever SRAM data_mode selected.
    assign act_push_data = (!is_os && dm_q == DM_WT) ? Q_wt : Q_act;

    assign CEN_xmem = !(issue && (is_os || dm_q == DM_ACT));
    assign CEN_pmem = !(issue && (is_os || dm_q == DM_WT));
    assign A_xmem   = addr_x;
    assign A_pmem   = addr_p;
    assign l0_wr    = wr_fire;
    assign ififo_wr = wr_fire && is_os;
    assign l0_in    = act_head;
    assign ififo_in = wt_head;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_OS;
            dm_q     <= DM_ACT;
            len_q    <= '0;
            issued   <= '0;
            written  <= '0;
            addr_x   <= '0;
            addr_p   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                issued <= issued + 1'b1;
                addr_x <= addr_x + 1'b1;
                addr_p <= addr_p + 1'b1;
            end
            if (wr_fire) begin
                written <= written + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        dm_q    <= data_mode;
                        len_q   <= len;
                        addr_x  <= base_x;
                        addr_p  <= base_p;
                        issued  <= '0;
                        written <= '0;
                        state   <= (len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issued == len_q) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Leave on the final write itself so done lands len+3 after start.
                    if (wr_fire && (written + 1'b1 == len_q)) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    feed_skid_fifo #(
        .WIDTH (DW),
        .DEPTH (SKID),
        .CW    (CW)
    ) u_act_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (act_push_data),
        .pop       (wr_fire),
        .head      (act_head),
        .count     (act_count)
    );

    feed_skid_fifo #(
        .WIDTH (DW),
        .DEPTH (SKID),
        .CW    (CW)
    ) u_wt_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight && is_os),
        .push_data (Q_wt),
        .pop       (wr_fire && is_os),
        .head      (wt_head),
        .count     (wt_count)
    );

endmodule

// File: tb/tb_core_feed_sequencer.sv
// tb/tb_core_feed_sequencer.sv - directed self-checking bench for core_feed_sequencer
module tb_core_feed_sequencer;

    localparam int AW   = 11;
    localparam int DW   = 32;
    localparam int SKID = 3;

    logic          clk = 1'b0;
    logic          reset, start, mode, data_mode;
    logic [AW-1:0] base_x, base_p, len;
    logic          busy, done, CEN_xmem, CEN_pmem;
    logic [AW-1:0] A_xmem, A_pmem;
    logic [DW-1:0] Q_act = '0;
    logic [DW-1:0] Q_wt = '0;
    logic [DW-1:0] l0_in, ififo_in;
    logic          l0_wr, l0_full, ififo_wr, ififo_full;

    int checks = 0;
    int fails  = 0;

    logic          r_cenx [64];
    logic          r_cenp [64];
    logic          r_l0w  [64];
    logic          r_ifw  [64];
    logic          r_busy [64];
    logic          r_done [64];
    logic [AW-1:0] r_ax   [64];
    logic [AW-1:0] r_ap   [64];
    logic [DW-1:0] r_l0d  [64];
    logic [DW-1:0] wl0 [$];
    logic [DW-1:0] wif [$];
    int            done_cycle, max_out, last_c;

    always #5 clk = ~clk;

    core_feed_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .data_mode  (data_mode),
        .base_x     (base_x),
        .base_p     (base_p),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .CEN_xmem   (CEN_xmem),
        .A_xmem     (A_xmem),
        .CEN_pmem   (CEN_pmem),
        .A_pmem     (A_pmem),
        .Q_act      (Q_act),
        .Q_wt       (Q_wt),
        .l0_in      (l0_in),
        .l0_wr      (l0_wr),
        .l0_full    (l0_full),
        .ififo_in   (ififo_in),
        .ififo_wr   (ififo_wr),
        .ififo_full (ififo_full)
    );

    function automatic logic [DW-1:0] xval(input logic [AW-1:0] a);
        return {8'hA1, 13'h0A5, a};
    endfunction

    function automatic logic [DW-1:0] pval(input logic [AW-1:0] a);
        return {8'hB2, 13'h1C3, a};
    endfunction

    // One-cycle-latency SRAM models.
    always @(posedge clk) begin
        if (!CEN_xmem) Q_act <= xval(A_xmem);
        if (!CEN_pmem) Q_wt  <= pval(A_pmem);
    end

    task automatic run_burst(input logic m, input logic dm, input logic [AW-1:0] bx,
                             input logic [AW-1:0] bp, input logic [AW-1:0] ln,
                             input int if_lo, input int if_hi, input int restart_c,
                             input int reset_c, input int max_c);
        int reads;
        int writes;
        reads = 0; writes = 0; done_cycle = -1; max_out = 0; last_c = 0;
        wl0.delete(); wif.delete();
        @(negedge clk);
        mode = m; data_mode = dm; base_x = bx; base_p = bp; len = ln; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= max_c; c++) begin
            ififo_full = (c >= if_lo && c <= if_hi);
            start = (c == restart_c);
            if (c == restart_c) begin
                len = '0; base_x = 11'd500; mode = ~m;
            end
            reset = (c == reset_c) ? 1'b0 : 1'b1;
            @(negedge clk);
            r_cenx[c] = CEN_xmem; r_cenp[c] = CEN_pmem; r_ax[c] = A_xmem; r_ap[c] = A_pmem;
            r_l0w[c] = l0_wr; r_ifw[c] = ififo_wr; r_l0d[c] = l0_in;
            r_busy[c] = busy; r_done[c] = done;
            if (!CEN_xmem || !CEN_pmem) reads++;
            if (reads - writes > max_out) max_out = reads - writes;
            if (l0_wr) begin wl0.push_back(l0_in); writes++; end
            if (ififo_wr) wif.push_back(ififo_in);
            if (done && done_cycle < 0) done_cycle = c;
            last_c = c;
            @(posedge clk); #1;
            if (done_cycle >= 0 && c > done_cycle) break;
        end
        start = 1'b0; ififo_full = 1'b0; reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_status busy=%b done=%b required 0 0", busy, done); fails++;
        end
        checks++;
        if (CEN_xmem !== 1'b1 || CEN_pmem !== 1'b1 || A_xmem !== '0 || A_pmem !== '0) begin
            $display("FAIL reset_sram cen=%b%b a=%0d/%0d required 11 0/0", CEN_xmem, CEN_pmem, A_xmem, A_pmem); fails++;
        end
        checks++;
        if (l0_wr !== 1'b0 || ififo_wr !== 1'b0 || l0_in !== '0 || ififo_in !== '0) begin
            $display("FAIL reset_write wr=%b%b l0_in=%h ififo_in=%h required 00 0 0", l0_wr, ififo_wr, l0_in, ififo_in); fails++;
        end
    endtask

    task automatic test_ws_basic();
        int bad;
        run_burst(1'b1, 1'b0, 11'd10, 11'd0, 11'd4, 0, -1, 0, 0, 20);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (r_cenx[c] !== 1'b0 || r_ax[c] !== AW'(10 + c - 1)) begin
                $display("FAIL ws_issue c%0d cen=%b a=%0d required 0 %0d", c, r_cenx[c], r_ax[c], 10 + c - 1); fails++;
            end
        end
        checks++;
        if (r_cenx[5] !== 1'b1) begin
            $display("FAIL ws_no_extra_read cen=%b required 1", r_cenx[5]); fails++;
        end
        bad = 0;
        for (int c = 1; c <= last_c; c++) if (r_cenp[c] !== 1'b1) bad++;
        checks++;
        if (bad != 0) begin
            $display("FAIL ws_pmem_idle low_cycles=%0d required 0", bad); fails++;
        end
        for (int c = 3; c <= 6; c++) begin
            checks++;
            if (r_l0w[c] !== 1'b1 || r_l0d[c] !== xval(AW'(10 + c - 3))) begin
                $display("FAIL ws_write c%0d wr=%b data=%h required 1 %h", c, r_l0w[c], r_l0d[c], xval(AW'(10 + c - 3))); fails++;
            end
        end
        checks++;
        if (r_l0w[2] !== 1'b0 || r_l0w[7] !== 1'b0) begin
            $display("FAIL ws_write_window c2=%b c7=%b required 0 0", r_l0w[2], r_l0w[7]); fails++;
        end
        checks++;
        if (done_cycle != 7) begin
            $display("FAIL ws_done_cycle got %0d required 7", done_cycle); fails++;
        end
        checks++;
        if (r_busy[1] !== 1'b1 || r_busy[last_c] !== 1'b0) begin
            $display("FAIL ws_busy first=%b after=%b required 1 0", r_busy[1], r_busy[last_c]); fails++;
        end
    endtask

    task automatic test_os_pair();
        int bad;
        run_burst(1'b0, 1'b0, 11'd0, 11'd100, 11'd3, 0, -1, 0, 0, 20);
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (r_cenx[c] !== 1'b0 || r_cenp[c] !== 1'b0 || r_ax[c] !== AW'(c - 1) || r_ap[c] !== AW'(100 + c - 1)) begin
                $display("FAIL os_issue c%0d cen=%b%b a=%0d/%0d required 00 %0d/%0d", c, r_cenx[c], r_cenp[c], r_ax[c], r_ap[c], c - 1, 100 + c - 1); fails++;
            end
        end
        bad = 0;
        for (int c = 1; c <= last_c; c++) if (r_l0w[c] !== r_ifw[c]) bad++;
        checks++;
        if (bad != 0) begin
            $display("FAIL os_lockstep unequal_cycles=%0d required 0", bad); fails++;
        end
        checks++;
        if (wl0.size() != 3 || wif.size() != 3) begin
            $display("FAIL os_count l0=%0d ififo=%0d required 3 3", wl0.size(), wif.size()); fails++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wl0[i] !== xval(AW'(i)) || wif[i] !== pval(AW'(100 + i))) begin
                    $display("FAIL os_pair %0d got %h/%h required %h/%h", i, wl0[i], wif[i], xval(AW'(i)), pval(AW'(100 + i))); fails++;
                end
            end
        end
        checks++;
        if (done_cycle != 6) begin
            $display("FAIL os_done_cycle got %0d required 6", done_cycle); fails++;
        end
    endtask

    task automatic test_os_backpressure();
        int bad;
        run_burst(1'b0, 1'b0, 11'd20, 11'd300, 11'd8, 4, 9, 0, 0, 40);
        bad = 0;
        for (int c = 4; c <= 9; c++) if (r_l0w[c] !== 1'b0 || r_ifw[c] !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            $display("FAIL bp_stall writes_during_stall=%0d required 0", bad); fails++;
        end
        checks++;
        if (max_out > SKID) begin
            $display("FAIL bp_outstanding got %0d required <= %0d", max_out, SKID); fails++;
        end
        checks++;
        if (wl0.size() != 8 || wif.size() != 8) begin
            $display("FAIL bp_count l0=%0d ififo=%0d required 8 8", wl0.size(), wif.size()); fails++;
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wl0[i] !== xval(AW'(20 + i)) || wif[i] !== pval(AW'(300 + i))) begin
                    $display("FAIL bp_order %0d got %h/%h required %h/%h", i, wl0[i], wif[i], xval(AW'(20 + i)), pval(AW'(300 + i))); fails++;
                end
            end
        end
        checks++;
        if (done_cycle != 17) begin
            $display("FAIL bp_done_cycle got %0d required 17", done_cycle); fails++;
        end
    endtask

    task automatic test_ws_wrap();
        logic [AW-1:0] exp_a [4];
        int bad;
        exp_a[0] = 11'd2046; exp_a[1] = 11'd2047; exp_a[2] = 11'd0; exp_a[3] = 11'd1;
        run_burst(1'b1, 1'b1, 11'd0, 11'd2046, 11'd4, 0, -1, 0, 0, 20);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (r_cenp[c] !== 1'b0 || r_ap[c] !== exp_a[c-1]) begin
                $display("FAIL wrap_addr c%0d cen=%b a=%0d required 0 %0d", c, r_cenp[c], r_ap[c], exp_a[c-1]); fails++;
            end
        end
        bad = 0;
        for (int c = 1; c <= last_c; c++) if (r_cenx[c] !== 1'b1) bad++;
        checks++;
        if (bad != 0) begin
            $display("FAIL wrap_xmem_idle low_cycles=%0d required 0", bad); fails++;
        end
        checks++;
        if (wl0.size() != 4) begin
            $display("FAIL wrap_count got %0d required 4", wl0.size()); fails++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wl0[i] !== pval(exp_a[i])) begin
                    $display("FAIL wrap_data %0d got %h required %h", i, wl0[i], pval(exp_a[i])); fails++;
                end
            end
        end
        checks++;
        if (done_cycle != 7) begin
            $display("FAIL wrap_done_cycle got %0d required 7", done_cycle); fails++;
        end
    endtask

    task automatic test_len_zero();
        int bad;
        run_burst(1'b1, 1'b0, 11'd5, 11'd5, 11'd0, 0, -1, 0, 0, 10);
        checks++;
        if (r_busy[1] !== 1'b1 || r_done[1] !== 1'b1) begin
            $display("FAIL len0_pulse busy=%b done=%b required 1 1", r_busy[1], r_done[1]); fails++;
        end
        checks++;
        if (last_c != 2 || r_busy[2] !== 1'b0 || r_done[2] !== 1'b0) begin
            $display("FAIL len0_return last=%0d busy=%b done=%b required 2 0 0", last_c, r_busy[2], r_done[2]); fails++;
        end
        bad = 0;
        for (int c = 1; c <= last_c; c++) if (r_cenx[c] !== 1'b1 || r_cenp[c] !== 1'b1) bad++;
        checks++;
        if (bad != 0) begin
            $display("FAIL len0_no_access low_cycles=%0d required 0", bad); fails++;
        end
        run_burst(1'b1, 1'b0, 11'd40, 11'd0, 11'd4, 0, -1, 2, 0, 20);
        checks++;
        if (done_cycle != 7 || r_ax[4] !== 11'd43) begin
            $display("FAIL ignore_start done=%0d a4=%0d required 7 43", done_cycle, r_ax[4]); fails++;
        end
        checks++;
        if (wl0.size() != 4 || wl0[0] !== xval(11'd40) || wl0[3] !== xval(11'd43)) begin
            $display("FAIL ignore_start_data n=%0d required 4 words from %h", wl0.size(), xval(11'd40)); fails++;
        end
    endtask

    task automatic test_reset_mid();
        run_burst(1'b1, 1'b0, 11'd200, 11'd0, 11'd16, 0, -1, 0, 5, 6);
        checks++;
        if (r_busy[5] !== 1'b1 || r_l0w[5] !== 1'b1) begin
            $display("FAIL midrst_active busy=%b wr=%b required 1 1", r_busy[5], r_l0w[5]); fails++;
        end
        checks++;
        if (r_busy[6] !== 1'b0 || r_done[6] !== 1'b0 || r_l0w[6] !== 1'b0 || r_cenx[6] !== 1'b1
            || r_cenp[6] !== 1'b1 || r_ax[6] !== '0 || r_l0d[6] !== '0) begin
            $display("FAIL midrst_idle busy=%b done=%b wr=%b cen=%b%b a=%0d d=%h required 0 0 0 11 0 0",
                     r_busy[6], r_done[6], r_l0w[6], r_cenx[6], r_cenp[6], r_ax[6], r_l0d[6]); fails++;
        end
        run_burst(1'b0, 1'b0, 11'd7, 11'd9, 11'd2, 0, -1, 0, 0, 20);
        checks++;
        if (done_cycle != 5) begin
            $display("FAIL midrst_rerun_done got %0d required 5", done_cycle); fails++;
        end
        checks++;
        if (wl0.size() != 2 || wif.size() != 2 || wl0[0] !== xval(11'd7) || wl0[1] !== xval(11'd8)
            || wif[0] !== pval(11'd9) || wif[1] !== pval(11'd10)) begin
            $display("FAIL midrst_rerun_data n=%0d/%0d required 2/2 pairs from %h/%h", wl0.size(), wif.size(), xval(11'd7), pval(11'd9)); fails++;
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; mode = 1'b0; data_mode = 1'b0;
        base_x = '0; base_p = '0; len = '0; l0_full = 1'b0; ififo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        test_ws_basic();
        test_os_pair();
        test_os_backpressure();
        test_ws_wrap();
        test_len_zero();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
